// File: rtl/frame_segmenter_pkg.sv
// Shared constants and helpers for the frame segmenter.
// The stream width is fixed here and used by every file of the block.
package frame_segmenter_pkg;

    localparam int DW   = 512;
    localparam int NB   = DW / 8;
    localparam int NB_W = $clog2(2 * NB);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    // Low-packed byte-keep mask with n lanes set.
    function automatic logic [NB-1:0] keep_mask(input logic [NB_W-1:0] n);
        keep_mask = '0;
        for (int i = 0; i < NB; i++) begin
            keep_mask[i] = (i < int'(n));
        end
    endfunction

endpackage

// File: rtl/frame_segmenter_if.sv
// AXI-Stream bundle used on both sides of the frame segmenter.
// The master drives data/valid/keep/last, the slave drives ready.
interface frame_segmenter_if;
    import frame_segmenter_pkg::*;

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic [NB-1:0] tkeep;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tkeep,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tkeep,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/frame_segmenter_byte_realign.sv
// Merges the residual bytes with an input beat, splits off one output
// beat and realigns the leftover bytes to lane 0.
module frame_segmenter_byte_realign
    import frame_segmenter_pkg::*;
(
    input  logic [2*DW-1:0] res_data,
    input  logic [NB_W-1:0] res_cnt,
    input  logic [DW-1:0]   in_data,
    input  logic [NB_W-1:0] in_cnt,
    input  logic [NB_W-1:0] out_cnt,
    output logic [DW-1:0]   beat_data,
    output logic [2*DW-1:0] next_data
);

    logic [NB_W-1:0] cnt;
    logic [NB_W-1:0] left;
    logic [DW-1:0]   in_keep;
    logic [2*DW-1:0] in_ext;
    logic [2*DW-1:0] res_keep;
    logic [2*DW-1:0] merged;
    logic [2*DW-1:0] shifted;

    always_comb begin
        cnt      = res_cnt + in_cnt;
        left     = cnt - out_cnt;
        // Input lanes past the keep count may carry garbage.
        in_keep  = in_data & ~({DW{1'b1}} << {in_cnt, 3'b000});
        in_ext   = {{DW{1'b0}}, in_keep};
        res_keep = res_data & ~({2*DW{1'b1}} << {res_cnt, 3'b000});
        merged   = res_keep | (in_ext << {res_cnt, 3'b000});
        beat_data = merged[DW-1:0]
                  & ~({DW{1'b1}} << {out_cnt, 3'b000});
        shifted   = merged >> {out_cnt, 3'b000};
        next_data = shifted
                  & ~({2*DW{1'b1}} << {left, 3'b000});
    end

endmodule

// File: rtl/frame_segmenter.sv
// Cuts a byte-packed AXI-Stream packet into frames of FRAME_SIZE bytes,
// marking each frame end with TLAST and carrying leftovers forward.
module frame_segmenter
    import frame_segmenter_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       FRAME_SIZE,
    frame_segmenter_if.slave  axis_in,
    frame_segmenter_if.master axis_out
);

    logic [0:0]      state;
    logic            loaded;
    logic [31:0]     frame_rem;
    logic [31:0]     fs_eff;
    logic [NB_W-1:0] r;
    logic [NB_W-1:0] need;
    logic [NB_W-1:0] k_in;
    logic [NB_W-1:0] k_eff;
    logic [NB_W-1:0] c;
    logic [NB_W-1:0] n;
    logic [NB_W-1:0] r_next;
    logic [2*DW-1:0] res;
    logic [2*DW-1:0] res_next;
    logic [DW-1:0]   beat;
    logic            load_en;
    logic            from_res;
    logic            accept;
    logic            emit;
    logic            pkt_end;
    logic            last;

    always_comb begin
        fs_eff   = (FRAME_SIZE == 32'd0) ? 32'(NB) : FRAME_SIZE;
        load_en  = !axis_out.tvalid || axis_out.tready;
        need     = (frame_rem < 32'(NB)) ? frame_rem[NB_W-1:0]
                                         : NB_W'(NB);
        k_in     = NB_W'($countones(axis_in.tkeep));
        // Drain the residual on its own whenever it covers a full beat.
        from_res = (state == FLUSH) || (r >= need);
        axis_in.tready = loaded && !from_res && load_en;
        accept   = axis_in.tvalid && axis_in.tready;
        k_eff    = accept ? k_in : '0;
        c        = r + k_eff;
        n        = (c < need) ? c : need;
        r_next   = c - n;
        emit     = loaded && (from_res ? load_en : accept);
        pkt_end  = ((state == FLUSH) || (accept && axis_in.tlast))
                && (r_next == '0);
        last     = (32'(n) == frame_rem) || pkt_end;
    end

    frame_segmenter_byte_realign u_realign (
        .res_data  (res),
        .res_cnt   (r),
        .in_data   (axis_in.tdata),
        .in_cnt    (k_eff),
        .out_cnt   (n),
        .beat_data (beat),
        .next_data (res_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= RUN;
            loaded          <= 1'b0;
            frame_rem       <= '0;
            r               <= '0;
            res             <= '0;
            axis_out.tvalid <= 1'b0;
            axis_out.tdata  <= '0;
            axis_out.tkeep  <= '0;
            axis_out.tlast  <= 1'b0;
        end else begin
            if (!loaded) begin
                loaded    <= 1'b1;
                frame_rem <= fs_eff;
            end
            if (emit) begin
                r         <= r_next;
                res       <= res_next;
                frame_rem <= last ? fs_eff : frame_rem - 32'(n);
                unique case (state)
                    RUN: begin
                        if (accept && axis_in.tlast && r_next != '0)
                            state <= FLUSH;
                    end
                    FLUSH: begin
                        if (r_next == '0)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
            if (load_en) begin
                axis_out.tvalid <= emit;
                if (emit) begin
                    axis_out.tdata <= beat;
                    axis_out.tkeep <= keep_mask(n);
                    axis_out.tlast <= last;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_segmenter.sv
// Directed bench for frame_segmenter: framing, residual realignment,
// flush, short frames, backpressure and asynchronous reset.
module tb_frame_segmenter;

    localparam int BW = 512;
    localparam int BB = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] frame_size = 32'd0;
    int          checks = 0;
    int          failures = 0;

    frame_segmenter_if axi();
    frame_segmenter_if axo();

    frame_segmenter dut (
        .clk        (clk),
        .resetn     (resetn),
        .FRAME_SIZE (frame_size),
        .axis_in    (axi),
        .axis_out   (axo)
    );

    always #5 clk = ~clk;

    logic [BB-1:0] got_keep[$];
    logic          got_last[$];
    logic [BW-1:0] got_data[$];
    int            exp_len[$];
    bit            exp_last[$];
    int            first_acc;
    int            first_out;
    int            lo_rdy;
    int            stall_bad;
    bit            timed_out;

    function automatic logic [7:0] pat(input int seed, input int b);
        return 8'((b * 5 + seed * 31 + 1) & 255);
    endfunction

    function automatic logic [BB-1:0] kmask(input int n);
        logic [BB-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [BW-1:0] beat_of(input int seed, input int off,
                                              input int n);
        logic [BW-1:0] d;
        d = '0;
        for (int j = 0; j < n; j++) d[8*j +: 8] = pat(seed, off + j);
        return d;
    endfunction

    task automatic drive_beat(input int seed, input int off, input int k,
                              input bit last);
        axi.tvalid = (k > 0);
        axi.tlast  = last;
        axi.tkeep  = kmask(k);
        for (int i = 0; i < BB; i++)
            axi.tdata[8*i +: 8] = (i < k) ? pat(seed, off + i) : 8'hAA;
    endtask

    task automatic do_reset(input logic [31:0] fs);
        @(negedge clk);
        resetn = 1'b0;
        frame_size = fs;
        axo.tready = 1'b1;
        drive_beat(0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Streams one packet and records every output beat transferred.
    task automatic run_packet(input int total, input int seed, input bit rnd);
        int sent;
        int cyc;
        int tail;
        int k;
        bit pstall;
        logic [BW-1:0] pd;
        logic [BB-1:0] pk;
        logic pl;
        sent = 0; cyc = 0; tail = 0; pstall = 0;
        pd = '0; pk = '0; pl = 1'b0;
        got_keep.delete(); got_last.delete(); got_data.delete();
        first_acc = -1; first_out = -1; lo_rdy = 0; stall_bad = 0;
        while (tail < 6 && cyc < 2000) begin
            @(negedge clk);
            axo.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k = (total - sent > BB) ? BB : total - sent;
            drive_beat(seed, sent, k, (k > 0) && (sent + k == total));
            #1;
            if (pstall && (!axo.tvalid || axo.tdata !== pd ||
                           axo.tkeep !== pk || axo.tlast !== pl))
                stall_bad++;
            pstall = axo.tvalid && !axo.tready;
            pd = axo.tdata; pk = axo.tkeep; pl = axo.tlast;
            if (axo.tvalid && !axi.tready) lo_rdy++;
            if (axo.tvalid && axo.tready) begin
                got_keep.push_back(axo.tkeep);
                got_last.push_back(axo.tlast);
                got_data.push_back(axo.tdata);
                if (first_out < 0) first_out = cyc;
            end
            if (axi.tvalid && axi.tready) begin
                if (first_acc < 0) first_acc = cyc;
                sent += k;
            end
            if (sent == total && got_keep.size() >= exp_len.size()) tail++;
            cyc++;
        end
        timed_out = (tail < 6);
        @(negedge clk);
        drive_beat(0, 0, 0, 1'b0);
        axo.tready = 1'b1;
    endtask

    task automatic test_reset_state;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (axo.tvalid !== 1'b0 || axo.tkeep !== '0 || axo.tlast !== 1'b0 ||
            axo.tdata !== '0 || axi.tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b keep=%h last=%b rdy=%b need all 0",
                     axo.tvalid, axo.tkeep, axo.tlast, axi.tready);
        end
    endtask

    task automatic test_full_frames;
        int off;
        do_reset(32'd128);
        exp_len = {64, 64, 64, 64};
        exp_last = {1'b0, 1'b1, 1'b0, 1'b1};
        run_packet(256, 1, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != exp_len.size()) begin
            failures++;
            $display("FAIL full_beats got=%0d need=%0d", got_keep.size(), exp_len.size());
        end
        checks++;
        if (first_out - first_acc != 1) begin
            failures++;
            $display("FAIL full_latency got=%0d need=1", first_out - first_acc);
        end
        off = 0;
        for (int i = 0; i < got_keep.size() && i < exp_len.size(); i++) begin
            checks++;
            if (got_keep[i] !== kmask(exp_len[i]) || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL full_beat%0d keep=%h last=%b need keep=%h last=%b",
                         i, got_keep[i], got_last[i], kmask(exp_len[i]), exp_last[i]);
            end
            checks++;
            if (got_data[i] !== beat_of(1, off, exp_len[i])) begin
                failures++;
                $display("FAIL full_data%0d got=%h need=%h", i, got_data[i],
                         beat_of(1, off, exp_len[i]));
            end
            off += exp_len[i];
        end
    endtask

    task automatic test_realign;
        int off;
        do_reset(32'd100);
        exp_len = {64, 36, 64, 36, 56};
        exp_last = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run_packet(256, 2, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != exp_len.size()) begin
            failures++;
            $display("FAIL realign_beats got=%0d need=%0d", got_keep.size(), exp_len.size());
        end
        off = 0;
        for (int i = 0; i < got_keep.size() && i < exp_len.size(); i++) begin
            checks++;
            if (got_keep[i] !== kmask(exp_len[i]) || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL realign_beat%0d keep=%h last=%b need keep=%h last=%b",
                         i, got_keep[i], got_last[i], kmask(exp_len[i]), exp_last[i]);
            end
            checks++;
            if (got_data[i] !== beat_of(2, off, exp_len[i])) begin
                failures++;
                $display("FAIL realign_data%0d got=%h need=%h", i, got_data[i],
                         beat_of(2, off, exp_len[i]));
            end
            off += exp_len[i];
        end
    endtask

    task automatic test_small_frames;
        int off;
        do_reset(32'd10);
        exp_len = {10, 10, 10, 10, 10, 10, 4};
        exp_last = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_packet(64, 3, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != exp_len.size()) begin
            failures++;
            $display("FAIL small_beats got=%0d need=%0d", got_keep.size(), exp_len.size());
        end
        checks++;
        if (lo_rdy != 6) begin
            failures++;
            $display("FAIL small_ready_low got=%0d need=6", lo_rdy);
        end
        off = 0;
        for (int i = 0; i < got_keep.size() && i < exp_len.size(); i++) begin
            checks++;
            if (got_keep[i] !== kmask(exp_len[i]) || got_last[i] !== exp_last[i] ||
                got_data[i] !== beat_of(3, off, exp_len[i])) begin
                failures++;
                $display("FAIL small_beat%0d keep=%h last=%b need keep=%h last=1",
                         i, got_keep[i], got_last[i], kmask(exp_len[i]));
            end
            off += exp_len[i];
        end
    endtask

    task automatic test_short_last;
        do_reset(32'd1000);
        exp_len = {64, 16};
        exp_last = {1'b0, 1'b1};
        run_packet(80, 4, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != 2) begin
            failures++;
            $display("FAIL short_beats got=%0d need=2", got_keep.size());
        end else begin
            checks++;
            if (got_keep[1] !== 64'h0000_0000_0000_FFFF || got_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL short_tail keep=%h last=%b need keep=ffff last=1",
                         got_keep[1], got_last[1]);
            end
            checks++;
            if (got_data[1] !== beat_of(4, 64, 16)) begin
                failures++;
                $display("FAIL short_data got=%h need=%h", got_data[1], beat_of(4, 64, 16));
            end
            checks++;
            if (got_keep[0] !== kmask(64) || got_last[0] !== 1'b0) begin
                failures++;
                $display("FAIL short_head keep=%h last=%b need all ones last=0",
                         got_keep[0], got_last[0]);
            end
        end
    endtask

    task automatic test_zero_size;
        do_reset(32'd0);
        exp_len = {64, 64};
        exp_last = {1'b1, 1'b1};
        run_packet(128, 5, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != 2 || got_last[0] !== 1'b1 ||
            got_last[1] !== 1'b1 || got_keep[0] !== kmask(64)) begin
            failures++;
            $display("FAIL zero_size beats=%0d need 2 full beats with last",
                     got_keep.size());
        end
    endtask

    task automatic test_backpressure;
        int off;
        do_reset(32'd100);
        exp_len = {64, 36, 64, 36, 64, 32};
        exp_last = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_packet(296, 6, 1'b1);
        checks++;
        if (timed_out || got_keep.size() != exp_len.size()) begin
            failures++;
            $display("FAIL bp_beats got=%0d need=%0d", got_keep.size(), exp_len.size());
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL bp_stable changes=%0d need=0", stall_bad);
        end
        off = 0;
        for (int i = 0; i < got_keep.size() && i < exp_len.size(); i++) begin
            checks++;
            if (got_keep[i] !== kmask(exp_len[i]) || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL bp_beat%0d keep=%h last=%b need keep=%h last=%b",
                         i, got_keep[i], got_last[i], kmask(exp_len[i]), exp_last[i]);
            end
            checks++;
            if (got_data[i] !== beat_of(6, off, exp_len[i])) begin
                failures++;
                $display("FAIL bp_data%0d got=%h need=%h", i, got_data[i],
                         beat_of(6, off, exp_len[i]));
            end
            off += exp_len[i];
        end
    endtask

    task automatic test_reset_mid_frame;
        do_reset(32'd100);
        @(negedge clk);
        drive_beat(7, 0, 64, 1'b0);
        #1;
        checks++;
        if (axi.tready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready got=%b need=1", axi.tready);
        end
        @(negedge clk);
        drive_beat(7, 64, 64, 1'b0);
        @(negedge clk);
        drive_beat(0, 0, 0, 1'b0);
        axo.tready = 1'b0;
        #1;
        checks++;
        if (axo.tvalid !== 1'b1 || axo.tkeep !== kmask(36) || axo.tlast !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre valid=%b keep=%h last=%b need 1/36 lanes/1",
                     axo.tvalid, axo.tkeep, axo.tlast);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (axo.tvalid !== 1'b0 || axo.tkeep !== '0 || axo.tlast !== 1'b0 ||
            axo.tdata !== '0 || axi.tready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async valid=%b keep=%h last=%b rdy=%b need all 0",
                     axo.tvalid, axo.tkeep, axo.tlast, axi.tready);
        end
        @(negedge clk);
        resetn = 1'b1;
        axo.tready = 1'b1;
        exp_len = {64};
        exp_last = {1'b1};
        run_packet(64, 9, 1'b0);
        checks++;
        if (timed_out || got_keep.size() != 1) begin
            failures++;
            $display("FAIL midrst_beats got=%0d need=1", got_keep.size());
        end else begin
            checks++;
            if (got_keep[0] !== kmask(64) || got_last[0] !== 1'b1 ||
                got_data[0] !== beat_of(9, 0, 64)) begin
                failures++;
                $display("FAIL midrst_fresh keep=%h last=%b data=%h need=%h",
                         got_keep[0], got_last[0], got_data[0], beat_of(9, 0, 64));
            end
        end
    endtask

    initial begin
        axo.tready = 1'b1;
        drive_beat(0, 0, 0, 1'b0);
        test_reset_state();
        test_full_frames();
        test_realign();
        test_small_frames();
        test_short_last();
        test_zero_size();
        test_backpressure();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_segmenter.md
Name: frame_segmenter

Overview:
- Upstream stage of the header-insertion block. Takes an unframed, byte-packed AXI-Stream packet and cuts it into frames of exactly FRAME_SIZE bytes.
- Marks the last beat of each frame with TLAST and a low-packed TKEEP, so the header stage sees one frame per TLAST.
- Bytes left over when a frame ends mid-beat are realigned to lane 0 and start the next frame.

Parameters:
- DW, 512, stream data width in bits; multiple of 8. NB = DW/8 bytes per beat.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- FRAME_SIZE  in  32  frame length in bytes; sampled at each frame start; 0 is treated as NB
- AXIS_IN_TDATA  in  DW  input data; byte i on bits [8i+7:8i]
- AXIS_IN_TVALID  in  1  input valid
- AXIS_IN_TKEEP  in  DW/8  all ones except on the TLAST beat, where it is low-packed and non-zero
- AXIS_IN_TLAST  in  1  end of input packet
- AXIS_IN_TREADY  out  1  input ready
- AXIS_OUT_TDATA  out  DW  output data; byte lanes past the valid count are 0
- AXIS_OUT_TVALID  out  1  output valid
- AXIS_OUT_TREADY  in  1  downstream ready
- AXIS_OUT_TKEEP  out  DW/8  low-packed keep
- AXIS_OUT_TLAST  out  1  last beat of frame

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - all outputs are 0 (TREADY=0, TVALID=0, TDATA/TKEEP/TLAST=0);
  - residual count r=0; state=RUN; frame_rem is loaded with FRAME_SIZE at the first cycle after reset.
- Reset mid-packet discards the residual bytes and the partial frame.
- Output register: single stage. It loads when load_en = !AXIS_OUT_TVALID || AXIS_OUT_TREADY. It holds TDATA/TKEEP/TLAST stable while TVALID=1 && TREADY=0.
- Latency: input accept to output TVALID is 1 cycle.
- Residual buffer: 2*NB bytes, count r in 0..2NB-2, valid bytes in lanes 0..r-1.
- Define need = min(NB, frame_rem).
- State RUN:
  - If r >= need: emit a beat from the residual only. AXIS_IN_TREADY=0.
  - Otherwise AXIS_IN_TREADY = load_en. On accept (k = popcount(TKEEP)):
    - combined bytes c = r + k; input bytes are appended at lane r;
    - emit n = min(need, c) bytes;
    - the remaining c-n bytes shift down to lane 0 and become the new r.
  - A non-last beat has k=NB, so c >= need and exactly one beat is emitted per accepted beat.
  - If an accepted TLAST beat leaves r>0: go to FLUSH.
- State FLUSH:
  - AXIS_IN_TREADY=0.
  - Each load_en cycle emits n = min(need, r) bytes.
  - Return to RUN when r reaches 0.
- Emitted beat fields:
  - TKEEP = (1<<n)-1.
  - TLAST = 1 when n == frame_rem, or when the beat holds the final byte of the input packet.
  - frame_rem -= n.
  - When TLAST is emitted, frame_rem reloads FRAME_SIZE (0 maps to NB). A new input packet always starts a new frame.
- Boundaries:
  - FRAME_SIZE < NB is legal; a single input beat may produce several frames, with TREADY held low while the residual drains.
  - Input TLAST that coincides with a frame end emits a single TLAST; there is no empty beat.
  - A short final frame (packet ends before frame_rem reaches 0) is emitted with TLAST.
  - Output backpressure stalls everything: no beat is dropped or duplicated, and r is unchanged during a stall.
- Width rules: frame_rem is 32 bits; r and n are clog2(2NB) bits; byte counts are computed by popcount of TKEEP.

Decomposition:
- Shared package/header: NB, NB_W=clog2(2NB), localparams RUN/FLUSH, and a keep-mask function (n -> low-packed mask).
- One sub-module: byte_realign. It is combinational and does the following:
  - merges the residual (2NB bytes, count r) with the input beat at offset r;
  - outputs the lower n bytes as the beat, with unused lanes zeroed;
  - outputs the upper c-n bytes shifted to lane 0 as the next residual.
- The top holds the FSM, counters, residual register and output register.

Test Plan:
- DW=512, FRAME_SIZE=128, a 4-beat full packet, TREADY=1 -> 4 output beats with TKEEP all ones and TLAST on beats 2 and 4; 1-cycle latency.
- FRAME_SIZE=100, a 4-beat (256 B) packet -> beats of 64/36(TLAST)/64/36(TLAST)/56(TLAST):
  - beat 3 is the residual 28 B plus the next input's first 36 B;
  - the final 56 B beat is emitted in FLUSH.
- FRAME_SIZE=10, 1 input beat of 64 B with TLAST -> 7 beats (6x10 B with TLAST, then 4 B with TLAST); AXIS_IN_TREADY=0 for 6 cycles.
- Last input beat TKEEP=0x0000_0000_0000_FFFF, FRAME_SIZE=1000 -> final output TKEEP=0xFFFF, TLAST=1, upper lanes of TDATA are 0.
- Random AXIS_OUT_TREADY (50%) with FRAME_SIZE=100 -> output byte stream equals the input byte stream; TDATA is stable while stalled; TLAST positions are correct.
- resetn pulsed low for 1 cycle mid-frame with r=28 -> outputs return to 0 asynchronously; the next packet starts a fresh frame with no residual bytes.
